// File: rtl/ring_pkg.sv
// Shared definitions for the ring-counter receive monitor.
// State encoding, default sizes and the ring rotate helper.
package ring_pkg;

  localparam int N_DEF  = 4;
  localparam int CW_DEF = 8;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_TRACK   = 1'b1
  } state_e;

  // Rotate the low n bits of v left by one; upper bits must be zero.
  function automatic logic [63:0] rotl(
    input logic [63:0] v,
    input int unsigned n
  );
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return ((v << 1) | (v >> (n - 1))) & m;
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot decoder: binary index plus a legality flag.
// The index is only meaningful when o_legal is set.
module onehot_to_bin #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_code,
  output logic [IW-1:0] o_idx,
  output logic          o_legal
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_code[i]) o_idx = o_idx | IW'(i);
    end
  end

  assign o_legal = (i_code != '0) &&
                   ((i_code & (i_code - 1'b1)) == '0);

endmodule

// File: rtl/ring_monitor.sv
// Ring phase decoder and health monitor for a one-hot ring bus.
// Define RING_ERR_CNT_EN to add the saturating err_cnt output.
module ring_monitor
  import ring_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [N-1:0]  ring_in,
  output logic [IW-1:0] idx,
  output logic          valid,
  output logic          onehot_err,
  output logic          seq_err,
  output logic          rev_tick,
  output logic [CW-1:0] rev_cnt,
`ifdef RING_ERR_CNT_EN
  output logic [7:0]    err_cnt,
`endif
  output logic          err_sticky
);

  state_e        r_state;
  logic [N-1:0]  r_exp;
  logic [IW-1:0] r_idx;
  logic          r_valid;
  logic          r_oh_err;
  logic          r_seq_err;
  logic          r_tick;
  logic [CW-1:0] r_rev_cnt;
  logic          r_sticky;

  logic [IW-1:0] w_idx;
  logic          w_legal;
  logic [N-1:0]  w_rot;
  logic          w_trk;
  logic          w_match;
  logic          w_oh_ev;
  logic          w_seq_ev;
  logic          w_tick_ev;
  logic          w_err_ev;

  onehot_to_bin #(
    .N  (N),
    .IW (IW)
  ) u_dec (
    .i_code  (ring_in),
    .o_idx   (w_idx),
    .o_legal (w_legal)
  );

  assign w_rot     = N'(rotl(64'(ring_in), N));
  assign w_trk     = (r_state == ST_TRACK);
  assign w_match   = (ring_in == r_exp);
  assign w_oh_ev   = en & ~w_legal;
  assign w_seq_ev  = en & w_legal & w_trk & ~w_match;
  // A wrap only counts when the tracked phase moves N-1 -> 0.
  assign w_tick_ev = en & w_legal & w_trk & w_match &
                     (r_idx == IW'(N - 1)) & ring_in[0];
  assign w_err_ev  = w_oh_ev | w_seq_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACQUIRE;
      r_exp   <= N'(1);
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      case (r_state)
        ST_ACQUIRE: begin
          if (w_legal) begin
            r_idx   <= w_idx;
            r_valid <= 1'b1;
            r_exp   <= w_rot;
            r_state <= ST_TRACK;
          end else begin
            r_valid <= 1'b0;
          end
        end
        ST_TRACK: begin
          if (!w_legal) begin
            r_valid <= 1'b0;
            r_state <= ST_ACQUIRE;
          end else begin
            r_idx   <= w_idx;
            r_valid <= 1'b1;
            r_exp   <= w_rot;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_ACQUIRE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_oh_err  <= 1'b0;
      r_seq_err <= 1'b0;
      r_tick    <= 1'b0;
      r_rev_cnt <= '0;
      r_sticky  <= 1'b0;
    end else begin
      r_oh_err  <= w_oh_ev;
      r_seq_err <= w_seq_ev;
      r_tick    <= w_tick_ev;
      if (clr) begin
        r_rev_cnt <= w_tick_ev ? CW'(1) : '0;
      end else if (w_tick_ev) begin
        r_rev_cnt <= r_rev_cnt + 1'b1;
      end
      if (w_err_ev) begin
        r_sticky <= 1'b1;
      end else if (clr) begin
        r_sticky <= 1'b0;
      end
    end
  end

`ifdef RING_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (clr) begin
      r_err_cnt <= w_err_ev ? 8'd1 : 8'd0;
    end else if (w_err_ev && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign idx        = r_idx;
  assign valid      = r_valid;
  assign onehot_err = r_oh_err;
  assign seq_err    = r_seq_err;
  assign rev_tick   = r_tick;
  assign rev_cnt    = r_rev_cnt;
  assign err_sticky = r_sticky;

endmodule

// File: doc/ring_monitor.md
Name: ring_monitor

Overview:
- Receiving end of the one-hot ring counter bus.
- Samples an N-bit ring phase bus and decodes the active bit to a binary index.
- Checks that every sample is one-hot and that each sample is the left-rotation of the previous one (bit k -> bit k+1, bit N-1 -> bit 0).
- Counts full revolutions and flags faults; sits beside any ring-counter-sequenced datapath as a health monitor and phase decoder.

Parameters:
- N, 4, ring width in bits; legal range N >= 2.
- CW, 8, revolution counter width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample strobe; ring_in is evaluated only when en=1.
- clr  input  1  synchronous clear of err_sticky and rev_cnt.
- ring_in  input  N  ring phase bus; bit 0 is the first phase after reset.
- idx  output  IW  binary index of the last legal sample; IW = clog2(N).
- valid  output  1  idx reflects a tracked legal phase.
- onehot_err  output  1  one-cycle pulse: sampled code was not one-hot.
- seq_err  output  1  one-cycle pulse: legal code, but not the expected next phase.
- rev_tick  output  1  one-cycle pulse on a tracked wrap from bit N-1 to bit 0.
- rev_cnt  output  CW  revolution count, wraps modulo 2^CW.
- err_sticky  output  1  set by any error; cleared only by clr or rst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - idx=0, valid=0, all pulses=0, rev_cnt=0, err_sticky=0, state=ACQUIRE.
  - rst has priority over en and clr.
- All outputs are registered. One-cycle latency from the sampling edge (en=1) to the idx, valid and error outputs.
- en=0: state, idx, valid and rev_cnt hold; onehot_err, seq_err and rev_tick are 0.
- Legal code: exactly one bit of ring_in is set. All-zero and multi-bit codes are illegal.
- State ACQUIRE:
  - Legal sample: load idx, valid=1, expected <= rotate-left(sample), go to TRACK. No rev_tick.
  - Illegal sample: onehot_err=1, valid=0, stay in ACQUIRE.
- State TRACK:
  - Sample == expected: load idx, update expected. If previous idx = N-1 and sample bit 0 is set: rev_tick=1 and rev_cnt increments.
  - Legal sample != expected (this includes a repeated, non-advancing code): seq_err=1, load idx, valid=1, resync expected from the sample, stay in TRACK. No rev_tick, rev_cnt unchanged.
  - Illegal sample: onehot_err=1, valid=0, idx holds, go to ACQUIRE.
- err_sticky:
  - Set when onehot_err or seq_err fires.
  - clr in the same cycle as a new error leaves err_sticky=1 (error wins).
- rev_cnt:
  - clr loads 0.
  - clr in the same cycle as rev_tick loads 1.
  - Wraps from 2^CW-1 to 0 silently.
- State encoding: ACQUIRE=0, TRACK=1. Any unreachable encoding returns to ACQUIRE.

Optional Feature:
- Macro: RING_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [7:0], reset to 0.
  - Increments on each onehot_err or seq_err pulse.
  - Saturates at 255; cleared by clr. If clr and an error coincide, err_cnt loads 1.
- Undefined: no err_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Package ring_pkg:
  - State encoding constants ST_ACQUIRE and ST_TRACK.
  - Default N and CW values.
  - Rotate-left helper function used by both RTL and bench.
- Sub-module onehot_to_bin (combinational):
  - Input: N-bit code.
  - Outputs: IW-bit index and a legal flag.
  - Instanced once inside ring_monitor.

Test Plan (N=4, CW=8):
- Reset then track: rst, then en=1 with ring_in 0001,0010,0100,1000,0001 -> idx 0,1,2,3,0; valid=1 from the first sample; a single rev_tick on the last sample; rev_cnt=1; no errors.
- Illegal code: while tracking with idx=1, feed ring_in=0110 -> onehot_err pulse, valid=0, idx stays 1, err_sticky=1. Then feed 0100 -> valid=1, idx=2, no seq_err.
- Sequence break: tracking at 0010, feed 1000 -> seq_err pulse, idx=3. Then feed 0001 -> idx=0, rev_tick=1, no seq_err.
- Stall and en gating:
  - Repeat 0100 with en=1 -> seq_err.
  - Toggle ring_in with en=0 -> no output change and no pulses.
- Clear races:
  - clr coincident with a seq_err -> err_sticky stays 1.
  - clr coincident with a rev_tick -> rev_cnt=1.
  - 256 revolutions -> rev_cnt wraps to 0.
- Reset mid-operation and feature build:
  - rst asserted in TRACK at idx=2 -> all outputs 0 next cycle, state ACQUIRE.
  - With RING_ERR_CNT_EN defined, 300 errors -> err_cnt=255.
